led_matrix_scan_ctrl: RTL and testbench
=======================================

# led_matrix_scan_ctrl

Scan sequencer for a HUB75-style LED matrix. It drives the panel shift clock, latch, output-enable and row address, and issues frame-buffer read addresses. It pulses `frame_sync` into the bit-plane modulation datapath once per fully scanned sub-frame. Each sub-frame has equal on-time, because the modulation datapath already applies the plane weighting by repeating planes, so this block needs no plane-weight logic.

## Interface
Parameters:
- `COLS`, default 64: columns shifted per row (≥2).
- `ROWS`, default 16: addressed row pairs per sub-frame (power of two).
- `BRIGHT_W`, default 10: width of the on-time value.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: **asynchronous, active-high** reset.
- `enable`, in, 1: run the scan; sampled in IDLE and at each LATCH.
- `brightness`, in, BRIGHT_W: OE-active cycles per row; sampled at LATCH.
- `pix_addr`, out, $clog2(ROWS)+$clog2(COLS): {row, col} buffer read address; buffer read latency is 1 cycle.
- `mat_clk`, out, 1: panel shift clock.
- `mat_lat`, out, 1: panel latch, 1-cycle pulse.
- `mat_oe_n`, out, 1: panel output enable, active low.
- `mat_addr`, out, $clog2(ROWS): displayed row address.
- `frame_sync`, out, 1: 1-cycle pulse that advances the modulation datapath.
- `active`, out, 1: high whenever not in IDLE.

## Operation
- States: IDLE, SHIFT, TAIL, WAIT, LATCH.
- **IDLE**
  - Go to SHIFT when `enable`=1.
  - `shift_row` holds its value.
- **SHIFT**
  - Each column uses 2 cycles: phase0 then phase1. Column counter runs 0..COLS-1.
  - Phase0 of column c: `pix_addr`={shift_row, c}. `mat_clk`=1 if c≥1, else 0.
  - Phase1: `mat_clk`=0.
  - After phase1 of column COLS-1, go to TAIL.
- **TAIL**
  - `mat_clk`=1 for 1 cycle, which clocks in the last column.
  - Go to LATCH if `oe_cnt`≤1, else go to WAIT.
- **WAIT**
  - `mat_clk`=0.
  - Stay until `oe_cnt`≤1, then go to LATCH.
- **LATCH**
  - `mat_lat`=1, `mat_addr`<=shift_row, load `oe_cnt`<=brightness.
  - If shift_row==ROWS-1: `frame_sync`=1 in this cycle and shift_row wraps to 0; otherwise shift_row increments.
  - Next state is SHIFT if `enable`=1, else IDLE.
- **OE counter**
  - `oe_cnt` decrements each cycle while nonzero, in any state.
  - `mat_oe_n`=0 exactly while `oe_cnt`≠0.
  - Display of row r therefore overlaps the shifting of row r+1.
- **Rules**
  - `mat_oe_n` is never 0 in a LATCH cycle.
  - `mat_clk` is never 1 in LATCH or WAIT.
  - `pix_addr` holds its value outside SHIFT.
- **Boundary conditions**
  - `brightness`=0: the panel stays blank and the scan still advances.
  - `brightness` > 2·COLS+1: WAIT absorbs the difference.
  - `enable` dropped mid-row: the row completes through LATCH, its display time runs out, then IDLE with `mat_oe_n`=1.
  - Re-enable resumes at the next row; there is no restart at row 0.
  - `brightness` changes are ignored except at LATCH.

## Timing
- Reset values: state=IDLE, counters 0, `mat_clk`=0, `mat_lat`=0, `mat_oe_n`=1, `mat_addr`=0, `pix_addr`=0, `frame_sync`=0, `active`=0.
- All outputs are registered.
- Reset asserted mid-operation blanks the panel immediately; the asynchronous reset forces `mat_oe_n`=1.
- Row period = max(2·COLS+1, B)+1 cycles, where B is the sampled brightness.
- Panel data is valid in phase1 and still held through the following `mat_clk` rising cycle: with 1-cycle buffer latency, data for column c appears one cycle after its address.
- `frame_sync` coincides with the LATCH of row ROWS-1, so the shift of row 0 of the next sub-frame uses the advanced plane.

## Structure
- Package `led_matrix_pkg`:
  - `scan_state_t` enum.
  - Default COLS/ROWS constants.
  - Address-width localparam functions.
- One sub-module, `led_matrix_oe_timer`:
  - Load/decrement counter.
  - Outputs `oe_n` and `le1` (count ≤1).
- The state machine, column/phase counter and row counter stay in the top module.

## Test plan
Bench parameters: COLS=4, ROWS=2, BRIGHT_W=8. Cycle 0 is the first cycle in IDLE with `enable`=1.
- **Reset:** assert `rst` mid-SHIFT → all outputs take their reset values within the same cycle; `mat_oe_n`=1.
- **B=20:**
  - SHIFT runs in cycles 1–8 and TAIL in cycle 9; `mat_clk`=1 in cycles 3, 5, 7, 9, giving exactly 4 rising edges.
  - LATCH row 0 at cycle 10: `mat_addr`=0, `mat_oe_n`=0 in cycles 11–30.
  - LATCH row 1 at cycle 31 with `frame_sync`=1.
- **B=3:**
  - `mat_oe_n`=0 in cycles 11–13.
  - LATCH row 1 at cycle 20 (period 10); WAIT is never entered.
- **B=0:** 10 rows → `mat_oe_n` stays 1 throughout; `frame_sync` pulses every 20 cycles; `mat_lat` pulses every 10.
- **Enable dropped at cycle 5:**
  - LATCH at cycle 10, then IDLE; `mat_oe_n`=0 for B cycles, then stays 1; `active`=0 from cycle 11.
  - Re-enable → the next shift uses row 1.
- **Pixel fetch:** a buffer model returning `pix_addr` as data → the panel model captures columns 0,1,2,3 of the expected row on `mat_clk` rising edges.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared definitions for the HUB75 LED matrix scan controller.
// Contents:
//   scan_state_t  - scan sequencer states
//   DEF_COLS/ROWS - default panel geometry
//   addr_w()      - address width for a count, never narrower than 1 bit
package led_matrix_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_TAIL,
      S_WAIT,
      S_LATCH
   } scan_state_t;

   localparam int DEF_COLS = 64;
   localparam int DEF_ROWS = 16;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_matrix_oe_timer.sv
// Row display-time counter for the LED matrix scan controller.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load_i    - load value_i into the counter (LATCH cycle)
//   value_i   - on-time in cycles
//   oe_n_o    - registered output enable, low while the count is nonzero
//   le1_o     - count is 0 or 1, i.e. display ends by the next cycle
module led_matrix_oe_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   output logic         oe_n_o,
   output logic         le1_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         oe_n_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // oe_n is registered from the next count so it tracks cnt_q exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         oe_n_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         oe_n_q <= (cnt_d == '0);
      end
   end

   assign oe_n_o = oe_n_q;
   assign le1_o  = (cnt_q <= W'(1));

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Scan sequencer for a HUB75-style LED matrix.
// Shifts one row of COLS pixels (two cycles per column), latches it, and
// lets the OE timer display it while the next row is shifted in.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   enable      - run the scan (sampled in IDLE and at LATCH)
//   brightness  - OE-active cycles per row (sampled at LATCH)
//   pix_addr    - {row, col} frame-buffer read address (1-cycle latency buffer)
//   mat_clk     - panel shift clock
//   mat_lat     - panel latch pulse
//   mat_oe_n    - panel output enable, active low
//   mat_addr    - displayed row address
//   frame_sync  - one pulse per fully scanned sub-frame
//   active      - high whenever not in IDLE
module led_matrix_scan_ctrl
   import led_matrix_pkg::*;
#(
   parameter int COLS     = DEF_COLS,
   parameter int ROWS     = DEF_ROWS,
   parameter int BRIGHT_W = 10
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  enable,
   input  logic [BRIGHT_W-1:0]                   brightness,
   output logic [addr_w(ROWS)+addr_w(COLS)-1:0]  pix_addr,
   output logic                                  mat_clk,
   output logic                                  mat_lat,
   output logic                                  mat_oe_n,
   output logic [addr_w(ROWS)-1:0]               mat_addr,
   output logic                                  frame_sync,
   output logic                                  active
);

   localparam int CW = addr_w(COLS);
   localparam int RW = addr_w(ROWS);

   scan_state_t     state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic            phase_q, phase_d;
   logic [RW-1:0]   row_q, row_d;
   logic [RW+CW-1:0] pix_addr_q, pix_addr_d;
   logic            mat_clk_q, mat_clk_d;
   logic            mat_lat_q, mat_lat_d;
   logic [RW-1:0]   mat_addr_q, mat_addr_d;
   logic            frame_sync_q, frame_sync_d;
   logic            active_q, active_d;
   logic            go_latch, start_shift;
   logic            oe_le1;

   led_matrix_oe_timer #(.W(BRIGHT_W)) u_oe_timer (
      .clk     (clk),
      .rst     (rst),
      .load_i  (state_q == S_LATCH),
      .value_i (brightness),
      .oe_n_o  (mat_oe_n),
      .le1_o   (oe_le1)
   );

   // Outputs are computed for the state being entered, so each registered
   // output lines up with the state it belongs to.
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      phase_d      = phase_q;
      row_d        = row_q;
      pix_addr_d   = pix_addr_q;
      mat_clk_d    = 1'b0;
      mat_lat_d    = 1'b0;
      mat_addr_d   = mat_addr_q;
      frame_sync_d = 1'b0;
      go_latch     = 1'b0;
      start_shift  = 1'b0;

      case (state_q)
         S_IDLE: begin
            start_shift = enable;
         end
         S_SHIFT: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else if (col_q == CW'(COLS - 1)) begin
               // TAIL supplies the rising edge for the last column.
               state_d   = S_TAIL;
               phase_d   = 1'b0;
               mat_clk_d = 1'b1;
            end else begin
               // Rising edge here clocks in the previous column's data.
               col_d      = col_q + 1'b1;
               phase_d    = 1'b0;
               pix_addr_d = {row_q, col_q + CW'(1)};
               mat_clk_d  = 1'b1;
            end
         end
         S_TAIL: begin
            if (oe_le1) go_latch = 1'b1;
            else        state_d  = S_WAIT;
         end
         S_WAIT: begin
            go_latch = oe_le1;
         end
         S_LATCH: begin
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            if (enable) start_shift = 1'b1;
            else        state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (go_latch) begin
         state_d      = S_LATCH;
         mat_lat_d    = 1'b1;
         mat_addr_d   = row_q;
         frame_sync_d = (row_q == RW'(ROWS - 1));
      end

      if (start_shift) begin
         state_d    = S_SHIFT;
         col_d      = '0;
         phase_d    = 1'b0;
         pix_addr_d = {row_d, CW'(0)};
      end

      active_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         phase_q      <= 1'b0;
         row_q        <= '0;
         pix_addr_q   <= '0;
         mat_clk_q    <= 1'b0;
         mat_lat_q    <= 1'b0;
         mat_addr_q   <= '0;
         frame_sync_q <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         phase_q      <= phase_d;
         row_q        <= row_d;
         pix_addr_q   <= pix_addr_d;
         mat_clk_q    <= mat_clk_d;
         mat_lat_q    <= mat_lat_d;
         mat_addr_q   <= mat_addr_d;
         frame_sync_q <= frame_sync_d;
         active_q     <= active_d;
      end
   end

   assign pix_addr   = pix_addr_q;
   assign mat_clk    = mat_clk_q;
   assign mat_lat    = mat_lat_q;
   assign mat_addr   = mat_addr_q;
   assign frame_sync = frame_sync_q;
   assign active     = active_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl with COLS=4, ROWS=2, BRIGHT_W=8.
// Cycle 0 is the first IDLE cycle with enable=1; cycle k is sampled 1 time
// unit after the k-th following rising edge.
module tb_led_matrix_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] brightness;
   logic [2:0] pix_addr;
   logic       mat_clk, mat_lat, mat_oe_n, frame_sync, active;
   logic [0:0] mat_addr;
   logic [2:0] buf_data;

   int vec_cnt = 0;
   int err_cnt = 0;
   int b_main;

   int tr_clk[0:127];
   int tr_lat[0:127];
   int tr_oe [0:127];
   int tr_adr[0:127];
   int tr_fs [0:127];
   int tr_act[0:127];
   int cap[$];

   led_matrix_scan_ctrl #(.COLS(4), .ROWS(2), .BRIGHT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .brightness (brightness),
      .pix_addr   (pix_addr),
      .mat_clk    (mat_clk),
      .mat_lat    (mat_lat),
      .mat_oe_n   (mat_oe_n),
      .mat_addr   (mat_addr),
      .frame_sync (frame_sync),
      .active     (active)
   );

   always #5 clk = ~clk;

   // Frame buffer model: returns the address as data, one cycle later.
   always @(posedge clk) buf_data <= pix_addr;

   task automatic chk(input string tag, input int obs, input int exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      enable     = 1'b0;
      brightness = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int k);
      tr_clk[k] = int'(mat_clk);
      tr_lat[k] = int'(mat_lat);
      tr_oe[k]  = int'(mat_oe_n);
      tr_adr[k] = int'(mat_addr);
      tr_fs[k]  = int'(frame_sync);
      tr_act[k] = int'(active);
   endtask

   // Called in cycle 0 with enable already set; records cycles 0..n.
   // Panel model: captures buffer data on each mat_clk rising cycle.
   task automatic run_trace(input int n, input int drop_at, input bit glitch);
      cap.delete();
      sample(0);
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         if (k == drop_at) enable = 1'b0;
         if (glitch) brightness = (k >= 2 && k <= 9) ? 8'd7 : 8'(b_main);
         sample(k);
         if (tr_clk[k] == 1 && tr_clk[k-1] == 0) cap.push_back(int'(buf_data));
      end
   endtask

   task automatic start(input int b);
      do_reset();
      b_main     = b;
      brightness = 8'(b);
      enable     = 1'b1;
   endtask

   initial begin
      int n_lo, n_lat, n_fs, bad_lat, bad_fs, n_act, n_clk;

      // ---------------- reset values ----------------
      do_reset();
      chk("rst_mat_clk",  int'(mat_clk), 0);
      chk("rst_mat_lat",  int'(mat_lat), 0);
      chk("rst_mat_oe_n", int'(mat_oe_n), 1);
      chk("rst_mat_addr", int'(mat_addr), 0);
      chk("rst_pix_addr", int'(pix_addr), 0);
      chk("rst_fsync",    int'(frame_sync), 0);
      chk("rst_active",   int'(active), 0);

      // ---------------- B=20, brightness glitch during shift ----------------
      start(20);
      run_trace(35, -1, 1'b1);
      chk("b20_active_c1", tr_act[1], 1);
      n_clk = 0;
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("b20_mat_clk_c%0d", k), tr_clk[k],
             (k == 3 || k == 5 || k == 7 || k == 9) ? 1 : 0);
         if (tr_clk[k] == 1 && tr_clk[k-1] == 0) n_clk++;
      end
      chk("b20_rising_edges", n_clk, 4);
      chk("b20_lat_c9",   tr_lat[9], 0);
      chk("b20_lat_c10",  tr_lat[10], 1);
      chk("b20_addr_c10", tr_adr[10], 0);
      chk("b20_fs_c10",   tr_fs[10], 0);
      for (int k = 10; k <= 31; k++)
         chk($sformatf("b20_oe_n_c%0d", k), tr_oe[k], (k >= 11 && k <= 30) ? 0 : 1);
      chk("b20_lat_c30",  tr_lat[30], 0);
      chk("b20_clk_c30",  tr_clk[30], 0);
      chk("b20_lat_c31",  tr_lat[31], 1);
      chk("b20_fs_c31",   tr_fs[31], 1);
      chk("b20_addr_c31", tr_adr[31], 1);
      // Pixel fetch: row 0 cols 0..3, row 1 cols 0..3, then row 0 col 0.
      chk("pix_cap_count", cap.size(), 9);
      for (int i = 0; i < 9 && i < cap.size(); i++)
         chk($sformatf("pix_cap_%0d", i), cap[i], (i < 8) ? i : 0);

      // ---------------- asynchronous reset mid-SHIFT ----------------
      chk("pre_rst_oe_n",  int'(mat_oe_n), 0);
      chk("pre_rst_pix",   int'(pix_addr), 1);
      chk("pre_rst_addr",  int'(mat_addr), 1);
      rst = 1'b1;
      #1;
      chk("arst_mat_oe_n", int'(mat_oe_n), 1);
      chk("arst_mat_clk",  int'(mat_clk), 0);
      chk("arst_mat_lat",  int'(mat_lat), 0);
      chk("arst_mat_addr", int'(mat_addr), 0);
      chk("arst_pix_addr", int'(pix_addr), 0);
      chk("arst_fsync",    int'(frame_sync), 0);
      chk("arst_active",   int'(active), 0);

      // ---------------- B=3: no WAIT, period 10 ----------------
      start(3);
      run_trace(21, -1, 1'b0);
      for (int k = 10; k <= 15; k++)
         chk($sformatf("b3_oe_n_c%0d", k), tr_oe[k], (k >= 11 && k <= 13) ? 0 : 1);
      chk("b3_clk_c19", tr_clk[19], 1);
      chk("b3_lat_c19", tr_lat[19], 0);
      chk("b3_lat_c20", tr_lat[20], 1);
      chk("b3_fs_c20",  tr_fs[20], 1);

      // ---------------- B=0: 10 rows, panel blank ----------------
      start(0);
      run_trace(100, -1, 1'b0);
      n_lo = 0; n_lat = 0; n_fs = 0; bad_lat = 0; bad_fs = 0;
      for (int k = 1; k <= 100; k++) begin
         if (tr_oe[k] == 0) n_lo++;
         if (tr_lat[k] == 1) begin
            n_lat++;
            if (k % 10 != 0) bad_lat++;
         end
         if (tr_fs[k] == 1) begin
            n_fs++;
            if (k % 20 != 0) bad_fs++;
         end
      end
      chk("b0_oe_low_cycles", n_lo, 0);
      chk("b0_lat_count",     n_lat, 10);
      chk("b0_lat_misplaced", bad_lat, 0);
      chk("b0_fs_count",      n_fs, 5);
      chk("b0_fs_misplaced",  bad_fs, 0);

      // ---------------- enable dropped at cycle 5, B=6 ----------------
      start(6);
      run_trace(25, 5, 1'b0);
      chk("drop_lat_c10", tr_lat[10], 1);
      chk("drop_act_c10", tr_act[10], 1);
      n_act = 0; n_clk = 0;
      for (int k = 11; k <= 25; k++) begin
         if (tr_act[k] == 1) n_act++;
         if (tr_clk[k] == 1) n_clk++;
         chk($sformatf("drop_oe_n_c%0d", k), tr_oe[k], (k <= 16) ? 0 : 1);
      end
      chk("drop_active_after", n_act, 0);
      chk("drop_clk_after",    n_clk, 0);

      // Re-enable: resumes with row 1.
      enable = 1'b1;
      run_trace(12, -1, 1'b0);
      chk("reen_first_pix", (cap.size() > 0) ? cap[0] : -1, 4);
      chk("reen_lat_c10",   tr_lat[10], 1);
      chk("reen_addr_c10",  tr_adr[10], 1);
      chk("reen_fs_c10",    tr_fs[10], 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
